stream_compare_run_ctrl: RTL
============================

Name: stream_compare_run_ctrl

Overview:
Run sequencer for a two-stream word comparator. On a start request it clears the comparator, waits a settle interval, then monitors the live word and error counters until a target word count, timeout or abort. It then pulses the comparator latch, captures final counts and reports pass/fail. Sits in the IP clock domain beside the comparator; the register-interface block drives its inputs and reads its outputs.

Parameters:
CNT_WIDTH, 32, width of word/error/cycle counters and targets
SETTLE_CYCLES, 4, cycles held in SETTLE after the comparator clear; must be >=1

Ports:
clk  input  1  IP clock; all logic on rising edge
aresetn  input  1  asynchronous active-low reset
start  input  1  level; rising edge while IDLE or DONE launches a run
abort  input  1  level; forces an early stop from SETTLE or RUN
word_target  input  CNT_WIDTH  words to compare per run; 0 = run until timeout/abort
timeout_cycles  input  CNT_WIDTH  max RUN cycles; 0 = no timeout
cmp_word_count  input  CNT_WIDTH  live comparator word counter
cmp_err_count  input  CNT_WIDTH  live comparator error counter
cmp_mismatch  input  1  registered per-word mismatch pulse from comparator
cmp_reset  output  1  one-cycle comparator counter clear
cmp_latch  output  1  one-cycle comparator snapshot request
busy  output  1  high in CLEAR, SETTLE, RUN, LATCH
done  output  1  high in DONE
pass  output  1  valid when done: result_errs==0 and not timed_out and not aborted
timed_out  output  1  sticky per run: ended by timeout
aborted  output  1  sticky per run: ended by abort (or first error, see option)
result_words  output  CNT_WIDTH  cmp_word_count captured in LATCH
result_errs  output  CNT_WIDTH  cmp_err_count captured in LATCH
run_cycles  output  CNT_WIDTH  RUN cycles elapsed; saturates at all-ones

Behaviour:
- Reset (async assert, sync deassert assumed upstream): state IDLE; all outputs 0.
- start edge detect: registered start_q; launch = start & ~start_q. Holding start high does not relaunch.
- IDLE: on launch -> CLEAR; clear timed_out, aborted, pass, result_*, run_cycles.
- CLEAR (1 cycle): cmp_reset=1 -> SETTLE; settle counter loaded to SETTLE_CYCLES-1.
- SETTLE: count down; at 0 -> RUN. abort -> LATCH with aborted=1.
- RUN: run_cycles increments each cycle (saturating). Exit priority, same cycle: abort > word target > timeout.
  - abort -> LATCH, aborted=1.
  - word_target!=0 and cmp_word_count>=word_target -> LATCH.
  - timeout_cycles!=0 and run_cycles+1>=timeout_cycles -> LATCH, timed_out=1. Timeout of N gives exactly N RUN cycles.
- LATCH: cmp_latch=1 for 1 cycle; next cycle (LATCH2, 1 cycle) capture result_words/result_errs from live inputs -> DONE. Capture happens one cycle after the latch pulse so comparator counts are frozen.
- DONE: done=1, pass computed once on entry and held. launch -> CLEAR (new run; results cleared). No other exit.
- start in busy states ignored; abort in IDLE/DONE/LATCH ignored.
- word_target/timeout_cycles sampled continuously; changing them mid-run takes effect next cycle.
- cmp_reset and cmp_latch never asserted together; each exactly one cycle per run.
- Counter compare unsigned full CNT_WIDTH; no wrap (run_cycles saturates).
- aresetn low mid-run: immediate return to IDLE, outputs 0, no latch pulse.

Optional Feature:
STREAM_COMPARE_STOP_ON_ERROR_EN: when defined, cmp_mismatch=1 in RUN ends the run (-> LATCH, aborted=1), priority between abort and word target. When undefined, cmp_mismatch is ignored and errors only affect pass via result_errs.

Test Plan:
- Launch, word_target=100, timeout=0, counts rise 1/cycle, no errors -> cmp_reset 1 cycle, SETTLE 4 cycles, cmp_latch when count reaches 100, done=1, pass=1, result_words>=100, result_errs=0.
- word_target=0, timeout_cycles=50 -> exactly 50 RUN cycles, timed_out=1, pass=0, run_cycles=50.
- Error counter reaches 3 during 100-word run -> result_errs=3, pass=0; with STOP_ON_ERROR_EN, run ends on first mismatch pulse, aborted=1.
- abort during SETTLE and again during RUN -> LATCH entered next cycle, aborted=1, done=1; start held high after DONE does not relaunch until dropped and reasserted.
- Same-cycle abort and target reached -> aborted=1; same-cycle target and timeout -> timed_out=0.
- aresetn pulled low mid-RUN -> all outputs 0 asynchronously, no cmp_latch; fresh launch after release runs normally.

Source files
------------

// File: rtl/stream_compare_run_ctrl_if.sv
// Signal bundle between the run sequencer, its register-interface block and the comparator.
// master = register block / comparator side, slave = run sequencer side.
interface stream_compare_run_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 start;
    logic                 abort;
    logic [CNT_WIDTH-1:0] word_target;
    logic [CNT_WIDTH-1:0] timeout_cycles;
    logic [CNT_WIDTH-1:0] cmp_word_count;
    logic [CNT_WIDTH-1:0] cmp_err_count;
    logic                 cmp_mismatch;
    logic                 cmp_reset;
    logic                 cmp_latch;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic                 timed_out;
    logic                 aborted;
    logic [CNT_WIDTH-1:0] result_words;
    logic [CNT_WIDTH-1:0] result_errs;
    logic [CNT_WIDTH-1:0] run_cycles;

    modport master (
        output start, abort, word_target, timeout_cycles,
        output cmp_word_count, cmp_err_count, cmp_mismatch,
        input  cmp_reset, cmp_latch, busy, done, pass, timed_out, aborted,
        input  result_words, result_errs, run_cycles
    );

    modport slave (
        input  start, abort, word_target, timeout_cycles,
        input  cmp_word_count, cmp_err_count, cmp_mismatch,
        output cmp_reset, cmp_latch, busy, done, pass, timed_out, aborted,
        output result_words, result_errs, run_cycles
    );
endinterface

// File: rtl/stream_compare_run_ctrl.sv
// Run sequencer for a two-stream word comparator: clear, settle, monitor, latch, report.
// Optional macro STREAM_COMPARE_STOP_ON_ERROR_EN ends a run on the first mismatch pulse.
module stream_compare_run_ctrl #(
    parameter int CNT_WIDTH     = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     aresetn,
    stream_compare_run_ctrl_if.slave bus
);

`ifdef STREAM_COMPARE_STOP_ON_ERROR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    localparam int             SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]  SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_RUN,
        S_LATCH,
        S_LATCH2,
        S_DONE
    } state_t;

    state_t               state;
    logic                 start_q;
    logic [SW-1:0]        settle_cnt;
    logic                 cmp_reset_r;
    logic                 cmp_latch_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 pass_r;
    logic                 timed_out_r;
    logic                 aborted_r;
    logic [CNT_WIDTH-1:0] result_words_r;
    logic [CNT_WIDTH-1:0] result_errs_r;
    logic [CNT_WIDTH-1:0] run_cycles_r;
    logic                 launch;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    function automatic logic target_hit(input logic [CNT_WIDTH-1:0] words,
                                        input logic [CNT_WIDTH-1:0] target);
        return (target != '0) && (words >= target);
    endfunction

    // Extra bit keeps run_cycles+1 from wrapping when run_cycles is all-ones.
    function automatic logic timeout_hit(input logic [CNT_WIDTH-1:0] cycles,
                                         input logic [CNT_WIDTH-1:0] limit);
        return (limit != '0) &&
               (({1'b0, cycles} + (CNT_WIDTH+1)'(1)) >= {1'b0, limit});
    endfunction

    assign launch = bus.start & ~start_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= S_IDLE;
            start_q        <= 1'b0;
            settle_cnt     <= '0;
            cmp_reset_r    <= 1'b0;
            cmp_latch_r    <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            pass_r         <= 1'b0;
            timed_out_r    <= 1'b0;
            aborted_r      <= 1'b0;
            result_words_r <= '0;
            result_errs_r  <= '0;
            run_cycles_r   <= '0;
        end else begin
            start_q     <= bus.start;
            cmp_reset_r <= 1'b0;
            cmp_latch_r <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (launch) begin
                        state          <= S_CLEAR;
                        cmp_reset_r    <= 1'b1;
                        busy_r         <= 1'b1;
                        done_r         <= 1'b0;
                        pass_r         <= 1'b0;
                        timed_out_r    <= 1'b0;
                        aborted_r      <= 1'b0;
                        result_words_r <= '0;
                        result_errs_r  <= '0;
                        run_cycles_r   <= '0;
                    end
                end

                S_CLEAR: begin
                    state      <= S_SETTLE;
                    settle_cnt <= SETTLE_LOAD;
                end

                S_SETTLE: begin
                    if (bus.abort) begin
                        state       <= S_LATCH;
                        cmp_latch_r <= 1'b1;
                        aborted_r   <= 1'b1;
                    end else if (settle_cnt == '0) begin
                        state <= S_RUN;
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end

                // Exit priority: abort, mismatch (optional), word target, timeout.
                S_RUN: begin
                    run_cycles_r <= sat_inc(run_cycles_r);
                    if (bus.abort) begin
                        state       <= S_LATCH;
                        cmp_latch_r <= 1'b1;
                        aborted_r   <= 1'b1;
                    end else if (STOP_ON_ERR && bus.cmp_mismatch) begin
                        state       <= S_LATCH;
                        cmp_latch_r <= 1'b1;
                        aborted_r   <= 1'b1;
                    end else if (target_hit(bus.cmp_word_count, bus.word_target)) begin
                        state       <= S_LATCH;
                        cmp_latch_r <= 1'b1;
                    end else if (timeout_hit(run_cycles_r, bus.timeout_cycles)) begin
                        state       <= S_LATCH;
                        cmp_latch_r <= 1'b1;
                        timed_out_r <= 1'b1;
                    end
                end

                S_LATCH: begin
                    state <= S_LATCH2;
                end

                // Comparator counts are frozen one cycle after the latch pulse.
                S_LATCH2: begin
                    state          <= S_DONE;
                    result_words_r <= bus.cmp_word_count;
                    result_errs_r  <= bus.cmp_err_count;
                    pass_r         <= (bus.cmp_err_count == '0) && !timed_out_r && !aborted_r;
                    busy_r         <= 1'b0;
                    done_r         <= 1'b1;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmp_reset    = cmp_reset_r;
    assign bus.cmp_latch    = cmp_latch_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.pass         = pass_r;
    assign bus.timed_out    = timed_out_r;
    assign bus.aborted      = aborted_r;
    assign bus.result_words = result_words_r;
    assign bus.result_errs  = result_errs_r;
    assign bus.run_cycles   = run_cycles_r;

endmodule
